// File: rtl/mfcc_ctrl_pkg.sv
// Shared types and helpers for the MFCC frame scheduler.
package mfcc_ctrl_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int FEAT_W_DEF   = 640;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_FEAT = 2'd2,
        ST_HOLD      = 2'd3
    } frame_state_t;

    // Ring pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mfcc_sample_ring.sv
// Sample ring storage: one write port, one registered read port (1-cycle latency).
// Pointer bookkeeping lives in the controller; this block only stores and reads.
module mfcc_sample_ring
    import mfcc_ctrl_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    localparam int AW      = $clog2(DEPTH)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    input  logic                i_rd_en,
    input  logic [AW-1:0]       i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data
);

    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [SAMPLE_W-1:0] r_rd_data;

    // Storage array has no reset; an empty ring is defined by the pointers.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; cleared on reset so the accelerator sees zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mfcc_frame_ctrl.sv
// MFCC frame scheduler: buffers the audio stream in a ring, cuts overlapping
// frames, streams each into the accelerator and returns the feature vector
// over a valid/ready port. Overflow and accelerator timeout are sticky.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | waiting for enable and a full frame in the ring
//  STREAM    | one ring read per cycle, FRAME_LEN reads in total
//  WAIT_FEAT | last sample on the bus, waiting for acc_feature_valid
//  HOLD      | feature vector presented until the consumer takes it
module mfcc_frame_ctrl
    import mfcc_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int HOP_LEN   = 128,
    parameter int BUF_DEPTH = 512,
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int FEAT_W    = FEAT_W_DEF,
    parameter int TIMEOUT   = 4096
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                in_valid,
    output logic [SAMPLE_W-1:0] acc_sample,
    output logic                acc_sample_valid,
    output logic                acc_frame_start,
    input  logic [FEAT_W-1:0]   acc_feature,
    input  logic                acc_feature_valid,
    output logic [FEAT_W-1:0]   feat_data,
    output logic                feat_valid,
    input  logic                feat_ready,
    output logic                overflow,
    output logic                timeout_err,
    output logic [15:0]         frame_count
);

    localparam int PW = ptr_w(BUF_DEPTH);
    localparam int AW = PW - 1;
    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [PW-1:0] DEPTH_P  = PW'(BUF_DEPTH);
    localparam logic [PW-1:0] FRAME_P  = PW'(FRAME_LEN);
    localparam logic [PW-1:0] HOP_P    = PW'(HOP_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    frame_state_t r_state;
    frame_state_t w_state_nxt;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_start_ptr;
    logic [CW-1:0]     r_rd_cnt;
    logic [TW-1:0]     r_timer;
    logic              r_smp_valid;
    logic              r_frame_start;
    logic [FEAT_W-1:0] r_feat_data;
    logic              r_feat_valid;
    logic              r_overflow;
    logic              r_timeout_err;
    logic [15:0]       r_frame_count;

    logic [PW-1:0]       w_fill;
    logic                w_wr_en;
    logic                w_drop;
    logic                w_start_frame;
    logic                w_rd_issue;
    logic                w_last_issue;
    logic [AW-1:0]       w_rd_addr;
    logic                w_feat_hit;
    logic                w_timeout;
    logic                w_handshake;
    logic [SAMPLE_W-1:0] w_ring_q;

    assign w_fill        = r_wr_ptr - r_start_ptr;
    assign w_wr_en       = in_valid && (w_fill < DEPTH_P);
    assign w_drop        = in_valid && (w_fill == DEPTH_P);
    assign w_start_frame = (r_state == ST_IDLE) && enable && (w_fill >= FRAME_P);
    assign w_rd_issue    = (r_state == ST_STREAM);
    assign w_last_issue  = w_rd_issue && (r_rd_cnt == LAST_CNT);
    assign w_rd_addr     = r_start_ptr[AW-1:0] + AW'(r_rd_cnt);
    assign w_feat_hit    = (r_state == ST_WAIT_FEAT) && acc_feature_valid;
    // A feature arriving in the final timer cycle still wins over the abort.
    assign w_timeout     = (r_state == ST_WAIT_FEAT) && !acc_feature_valid && (r_timer == '0);
    assign w_handshake   = (r_state == ST_HOLD) && feat_ready;

    mfcc_sample_ring #(
        .DEPTH    (BUF_DEPTH),
        .SAMPLE_W (SAMPLE_W)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (in_sample),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ring_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_frame) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_last_issue) w_state_nxt = ST_WAIT_FEAT;
            end
            ST_WAIT_FEAT: begin
                if (w_feat_hit)     w_state_nxt = ST_HOLD;
                else if (w_timeout) w_state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (w_handshake) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ring pointers; a write and a hop can land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_start_ptr <= '0;
        end else begin
            if (w_wr_en)      r_wr_ptr    <= r_wr_ptr + PW'(1);
            if (w_last_issue) r_start_ptr <= r_start_ptr + HOP_P;
        end
    end

    // Read offset within the frame and the feature wait timer (counts down).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_timer  <= '0;
        end else begin
            if (w_start_frame)   r_rd_cnt <= '0;
            else if (w_rd_issue) r_rd_cnt <= r_rd_cnt + CW'(1);

            if (w_last_issue)
                r_timer <= TMO_LOAD;
            else if ((r_state == ST_WAIT_FEAT) && (r_timer != '0))
                r_timer <= r_timer - TW'(1);
        end
    end

    // Sample-valid and frame-start track the read issue by the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_smp_valid   <= w_rd_issue;
            r_frame_start <= w_rd_issue && (r_rd_cnt == '0);
        end
    end

    // Feature latch, consumer handshake and delivered-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat_data   <= '0;
            r_feat_valid  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_feat_hit) begin
                r_feat_data  <= acc_feature;
                r_feat_valid <= 1'b1;
            end else if (w_handshake) begin
                r_feat_valid <= 1'b0;
            end
            if (w_handshake) r_frame_count <= r_frame_count + 16'd1;
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_drop)    r_overflow    <= 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign acc_sample       = w_ring_q;
    assign acc_sample_valid = r_smp_valid;
    assign acc_frame_start  = r_frame_start;
    assign feat_data        = r_feat_data;
    assign feat_valid       = r_feat_valid;
    assign overflow         = r_overflow;
    assign timeout_err      = r_timeout_err;
    assign frame_count      = r_frame_count;

endmodule

// File: tb/tb_mfcc_frame_ctrl.sv
// Bench for mfcc_frame_ctrl: directed scenarios followed by randomized rounds,
// checked against a sample-history model of the ring and frame sequence.
module tb_mfcc_frame_ctrl;

    localparam int FL  = 8;
    localparam int HOP = 4;
    localparam int BD  = 16;
    localparam int TO  = 32;
    localparam int SW  = 16;
    localparam int FW  = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [SW-1:0] in_sample = '0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] acc_feature = '0;
    logic          acc_feature_valid = 1'b0;
    logic          feat_ready = 1'b0;

    logic [SW-1:0] acc_sample;
    logic          acc_sample_valid;
    logic          acc_frame_start;
    logic [FW-1:0] feat_data;
    logic          feat_valid;
    logic          overflow;
    logic          timeout_err;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    mfcc_frame_ctrl #(
        .FRAME_LEN (FL),
        .HOP_LEN   (HOP),
        .BUF_DEPTH (BD),
        .SAMPLE_W  (SW),
        .FEAT_W    (FW),
        .TIMEOUT   (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .in_sample         (in_sample),
        .in_valid          (in_valid),
        .acc_sample        (acc_sample),
        .acc_sample_valid  (acc_sample_valid),
        .acc_frame_start   (acc_frame_start),
        .acc_feature       (acc_feature),
        .acc_feature_valid (acc_feature_valid),
        .feat_data         (feat_data),
        .feat_valid        (feat_valid),
        .feat_ready        (feat_ready),
        .overflow          (overflow),
        .timeout_err       (timeout_err),
        .frame_count       (frame_count)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    // Model: every accepted sample in arrival order; a frame starts at m_start.
    logic [SW-1:0] hist[$];
    int m_start  = 0;
    int m_frames = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_fill();
        return hist.size() - m_start;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic feed(input logic [SW-1:0] v);
        if (m_fill() < BD) hist.push_back(v);
        in_sample = v;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_smp_valid"}, FW'(acc_sample_valid), '0);
        chk({pfx, "_smp"},       FW'(acc_sample),       '0);
        chk({pfx, "_fstart"},    FW'(acc_frame_start),  '0);
        chk({pfx, "_feat_vld"},  FW'(feat_valid),       '0);
        chk({pfx, "_feat"},      feat_data,             '0);
        chk({pfx, "_ovf"},       FW'(overflow),         '0);
        chk({pfx, "_tmo"},       FW'(timeout_err),      '0);
        chk({pfx, "_fcount"},    FW'(frame_count),      '0);
    endtask

    task automatic model_reset();
        hist.delete();
        m_start  = 0;
        m_frames = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("rst");
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    // One complete frame: stream check, accelerator reply, hold, handshake.
    task automatic run_frame(input int rdly, input int hdly, input logic [FW-1:0] pat,
                             input bit noisy, input bit no_resp, input bit drop_en);
        bit seen = 1'b0;
        int guard = 0;
        while (!seen && guard < 40) begin
            step();
            guard++;
            seen = acc_frame_start;
        end
        chk("frame_start_seen", FW'(seen), FW'(1));
        if (!seen) begin
            m_start = hist.size();
            return;
        end
        if (drop_en) enable = 1'b0;
        for (int j = 0; j < FL; j++) begin
            if (j > 0) step();
            chk("smp_valid", FW'(acc_sample_valid), FW'(1));
            chk("smp_start", FW'(acc_frame_start), FW'(j == 0));
            chk("smp_data",  FW'(acc_sample), FW'(hist[m_start + j]));
            if (noisy && j < FL - 1) begin
                acc_feature_valid = 1'($urandom_range(0, 1));
                acc_feature       = {$urandom, $urandom};
            end else begin
                acc_feature_valid = 1'b0;
            end
        end
        m_start += HOP;

        if (no_resp) begin
            for (int w = 2; w <= TO; w++) begin
                step();
                if (w == 2) chk("post_frame_idle", FW'(acc_sample_valid), '0);
            end
            chk("tmo_not_early", FW'(timeout_err), '0);
            step();
            chk("tmo_flag", FW'(timeout_err), FW'(1));
            chk("tmo_no_feat", FW'(feat_valid), '0);
            step();
            chk("tmo_count", FW'(frame_count), FW'(m_frames % 65536));
            return;
        end

        for (int i = 0; i < rdly; i++) step();
        acc_feature       = pat;
        acc_feature_valid = 1'b1;
        step();
        acc_feature_valid = 1'b0;
        chk("feat_valid_set", FW'(feat_valid), FW'(1));
        chk("feat_data", feat_data, pat);

        for (int i = 0; i < hdly; i++) begin
            if (noisy) begin
                acc_feature_valid = 1'b1;
                acc_feature       = ~pat;
            end
            step();
            chk("hold_valid", FW'(feat_valid), FW'(1));
            chk("hold_data", feat_data, pat);
            chk("hold_no_stream", FW'(acc_sample_valid), '0);
        end
        acc_feature_valid = 1'b0;
        feat_ready = 1'b1;
        step();
        feat_ready = 1'b0;
        m_frames++;
        chk("hs_valid_clr", FW'(feat_valid), '0);
        chk("frame_count", FW'(frame_count), FW'(m_frames % 65536));

        if (drop_en) begin
            for (int i = 0; i < 5; i++) begin
                step();
                chk("en_blocks_start", FW'(acc_sample_valid), '0);
            end
            enable = 1'b1;
        end
    endtask

    initial begin
        #1;
        chk_zero("por");
        step();
        step();
        rst_n = 1'b1;

        // Basic frame.
        enable = 1'b1;
        for (int v = 1; v <= 8; v++) feed(SW'(v));
        run_frame(5, 3, {8{8'hA5}}, 1'b0, 1'b0, 1'b0);

        // Overlapping second frame: 5..12.
        for (int v = 9; v <= 12; v++) feed(SW'(v));
        run_frame(2, 2, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);

        // Overflow on a fresh buffer, then three overlapping frames drain it.
        do_reset();
        enable = 1'b0;
        for (int v = 1; v <= 16; v++) feed(SW'(v));
        chk("ovf_at_full", FW'(overflow), '0);
        feed(SW'(17));
        chk("ovf_drop", FW'(overflow), FW'(1));
        enable = 1'b1;
        for (int f = 0; f < 3; f++)
            run_frame($urandom_range(0, 10), $urandom_range(0, 3), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

        // Accelerator never answers.
        enable = 1'b0;
        for (int v = 0; v < 4; v++) feed(SW'($urandom));
        enable = 1'b1;
        run_frame(0, 0, '0, 1'b0, 1'b1, 1'b0);

        // Consumer backpressure with 12 samples buffered.
        enable = 1'b0;
        for (int v = 0; v < 8; v++) feed(SW'($urandom));
        enable = 1'b1;
        run_frame(3, 20, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        run_frame($urandom_range(0, 10), 0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

        // Reset on the 4th streamed sample.
        enable = 1'b0;
        for (int v = 0; v < 4; v++) feed(SW'($urandom));
        enable = 1'b1;
        begin
            int guard = 0;
            while (!acc_frame_start && guard < 40) begin
                step();
                guard++;
            end
            chk("rst_frame_seen", FW'(acc_frame_start), FW'(1));
        end
        for (int i = 0; i < 3; i++) step();
        chk("rst_4th_smp_valid", FW'(acc_sample_valid), FW'(1));
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        rst_n = 1'b1;
        model_reset();
        for (int v = 0; v < 7; v++) feed(SW'($urandom));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_frame_below_len", FW'(acc_sample_valid), '0);
        end
        feed(SW'($urandom));
        run_frame(4, 1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

        // Randomized rounds; the first one also drops enable mid-frame.
        for (int r = 0; r < 6; r++) begin
            int n;
            bit first;
            enable = 1'b0;
            n = (r == 0) ? (BD - m_fill()) : $urandom_range(1, BD - m_fill());
            for (int v = 0; v < n; v++) feed(SW'($urandom));
            enable = 1'b1;
            first = 1'b1;
            while (m_fill() >= FL) begin
                run_frame($urandom_range(0, 10), $urandom_range(0, 4), {$urandom, $urandom},
                          1'b1, 1'b0, (r == 0) && first);
                first = 1'b0;
            end
        end
        chk("end_no_ovf", FW'(overflow), '0);
        chk("end_no_tmo", FW'(timeout_err), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mfcc_frame_ctrl.md
Name: mfcc_frame_ctrl

Overview:
Frame scheduler in front of the MFCC accelerator. It buffers the continuous audio sample stream in a ring buffer and cuts it into overlapping frames (FRAME_LEN samples, advancing by HOP_LEN). It streams each frame into the accelerator, waits for the feature vector and returns it over a valid/ready interface. Overflow and accelerator timeout are reported as sticky status.

Parameters:
FRAME_LEN, 256, samples per frame (power of 2, <= BUF_DEPTH)
HOP_LEN, 128, samples between frame starts (1..FRAME_LEN)
BUF_DEPTH, 512, ring buffer depth in samples (power of 2)
SAMPLE_W, 16, audio sample width
FEAT_W, 640, feature vector width (40 x 16)
TIMEOUT, 4096, max cycles in WAIT_FEAT before abort

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  permits starting new frames
in_sample  in  SAMPLE_W  audio sample
in_valid  in  1  in_sample valid this cycle (no backpressure)
acc_sample  out  SAMPLE_W  sample to accelerator
acc_sample_valid  out  1  acc_sample valid
acc_frame_start  out  1  high with first sample of each frame
acc_feature  in  FEAT_W  accelerator feature output
acc_feature_valid  in  1  acc_feature valid pulse
feat_data  out  FEAT_W  latched feature vector
feat_valid  out  1  feat_data valid
feat_ready  in  1  consumer accepts feat_data
overflow  out  1  sticky: sample dropped
timeout_err  out  1  sticky: accelerator timed out
frame_count  out  16  completed frames delivered, wraps at 2^16

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, wr_ptr=start_ptr=0 (buffer empty), sticky flags cleared. Reset mid-operation discards the frame in progress.
- Pointers are log2(BUF_DEPTH)+1 bits. fill = wr_ptr - start_ptr.
- Write: in_valid and fill < BUF_DEPTH -> store at wr_ptr, wr_ptr+1. in_valid with fill == BUF_DEPTH -> sample dropped, overflow<=1. Writes are accepted in every state.
- FSM IDLE / STREAM / WAIT_FEAT / HOLD.
- IDLE: enable and fill >= FRAME_LEN -> STREAM, rd_cnt=0.
- STREAM: issue one RAM read per cycle at start_ptr+rd_cnt. RAM read latency is 1.
  - acc_sample_valid is the read-issue signal delayed 1 cycle, giving exactly FRAME_LEN consecutive valid cycles.
  - acc_frame_start accompanies the first valid sample.
  - On the last read issue: start_ptr += HOP_LEN (same cycle as any write; fill uses both updates) -> WAIT_FEAT, timer=0.
  - The final sample is presented in the first WAIT_FEAT cycle.
- WAIT_FEAT: acc_feature_valid -> feat_data<=acc_feature, feat_valid<=1 -> HOLD. If timer reaches TIMEOUT-1 with no valid -> timeout_err<=1 -> IDLE; the frame is discarded and frame_count is unchanged.
- HOLD: feat_valid=1 and feat_data held stable until feat_ready. On feat_valid&feat_ready: feat_valid<=0, frame_count+1 -> IDLE. No new frame starts in HOLD.
- acc_feature_valid outside WAIT_FEAT is ignored.
- enable deasserted mid-frame: the current frame completes; only new starts are blocked.
- Start latency: IDLE->STREAM at cycle t; first acc_sample_valid at t+2.

Decomposition:
- Package mfcc_ctrl_pkg: FSM state enum, FEAT_W/SAMPLE_W constants, pointer width function (clog2+1).
- Sub-module mfcc_sample_ring: dual-port ring RAM (1 write port, 1 registered read port, 1-cycle latency). Controller owns the pointers.

Test Plan:
(Bench parameters: FRAME_LEN=8, HOP_LEN=4, BUF_DEPTH=16, TIMEOUT=32.)
1. Basic frame: enable=1, feed 0x0001..0x0008; accelerator answers 5 cycles after the last sample with 0xA5 pattern -> acc_sample streams 1..8 contiguously, acc_frame_start with 0x0001; feat_data=pattern, feat_valid held; after feat_ready, frame_count=1.
2. Overlap: feed 9..12 after case 1 -> second frame streams 5..12; frame_count=2 after handshake.
3. Overflow: enable=0, feed 17 samples 1..17 -> overflow=1, fill=16, sample 17 dropped; set enable=1 -> frames stream 1..8, then 5..12, then 9..16.
4. Timeout: stream a frame, never assert acc_feature_valid -> timeout_err=1 after 32 WAIT_FEAT cycles, return to IDLE, feat_valid stays 0, frame_count unchanged.
5. Backpressure: feat_ready=0 for 20 cycles with 12 samples buffered -> feat_data stable, no acc_sample_valid during HOLD; the next frame starts after feat_ready=1.
6. Reset mid-STREAM: assert rst_n=0 on the 4th sample -> all outputs 0 immediately, fill=0; after release, 8 new samples produce a clean frame.
